// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, result and status out.
// The master drives requests; the slave (the ALU) drives results and flags.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             zero;
    logic             ovf;

    modport master (
        output start, op, data1, data2,
        input  result, busy, done, zero, ovf
    );

    modport slave (
        input  start, op, data1, data2,
        output result, busy, done, zero, ovf
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle FWD/ADD/SUB/AND/OR, iterative shift-add MUL, DONE pulse.
// Define ALU_SAT_EN to clamp overflowing ADD/SUB results to the signed range limits.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StFin  = 2'd2;

    localparam logic [2:0] OpFwd = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] acc_d;

    always_comb begin
        sum     = bus.data1 + bus.data2;
        diff    = bus.data1 - bus.data2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OpFwd: alu_res = bus.data2;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            OpAnd: alu_res = bus.data1 & bus.data2;
            OpOr:  alu_res = bus.data1 | bus.data2;
            OpSub: begin
                alu_res = diff;
                alu_ovf = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.data1[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
`ifdef ALU_SAT_EN
        // On overflow the true result always has the sign of data1.
        if (alu_ovf) begin
            alu_res = bus.data1[WIDTH-1] ? SatMin : SatMax;
        end
`endif
    end

    // Low WIDTH bits of an unsigned shift-add equal those of the signed product.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                StIdle, StFin: begin
                    if (bus.start) begin
                        if (bus.op == OpMul) begin
                            state_q  <= StMul;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            mcand_q  <= bus.data1;
                            mplier_q <= bus.data2;
                        end else begin
                            state_q  <= StFin;
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMul: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_q  <= StFin;
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        ovf_q    <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q == StMul);
    assign bus.done   = (state_q == StFin);
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): stimulus pushes expected results, a monitor checks DONE.
// Expected values honour ALU_SAT_EN when the bench is built with it.
module tb_seq_alu;
    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_RSV = 3'b110;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       o;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] r, input logic z, input logic o, input int c);
        exp_t e;
        e.res = r;
        e.z   = z;
        e.o   = o;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(bus.result), 32'(e.res));
                check("zero", 32'(bus.zero), 32'(e.z));
                check("ovf", 32'(bus.ovf), 32'(e.o));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic ez, input logic eo);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.data1 = a;
        bus.data2 = b;
        push_exp(er, ez, eo, cyc + 1 + ((o == OP_MUL) ? 8 : 0));
        @(negedge clk);
        bus.start = 1'b0;
        bus.data1 = 8'hA5;
        bus.data2 = 8'h5A;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bus.start = 1'b0;
        bus.op    = OP_FWD;
        bus.data1 = '0;
        bus.data2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        issue(OP_ADD, 8'd25, 8'd3, 8'd28, 1'b0, 1'b0);
        issue(OP_SUB, 8'd6, 8'd8, 8'hFE, 1'b0, 1'b0);
        issue(OP_FWD, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0);
        issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        issue(OP_OR, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0);

        // MUL 6*-2 with a START (ADD 1,1) held during BUSY that must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.data1 = 8'd6;
        bus.data2 = 8'hFE;
        push_exp(8'hF4, 1'b0, 1'b0, cyc + 9);
        @(negedge clk);
        bus.op    = OP_ADD;
        bus.data1 = 8'd1;
        bus.data2 = 8'd1;
        check("mul_busy_after_accept", 32'(bus.busy), 32'd1);
        nb = 0;
        while (bus.busy === 1'b1 && nb < 20) begin
            nb++;
            if (nb == 3) bus.start = 1'b0;
            @(negedge clk);
        end
        check("mul_busy_cycles", 32'(nb), 32'd8);
        repeat (2) @(negedge clk);
        check("mul_result_holds", 32'(bus.result), 32'hF4);
        check("mul_no_extra_done", 32'(bus.done), 32'd0);

`ifdef ALU_SAT_EN
        issue(OP_ADD, 8'd100, 8'd50, 8'h7F, 1'b0, 1'b1);
        issue(OP_SUB, 8'h9C, 8'd50, 8'h80, 1'b0, 1'b1);
        issue(OP_ADD, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1);
        issue(OP_SUB, 8'h00, 8'h80, 8'h7F, 1'b0, 1'b1);
`else
        issue(OP_ADD, 8'd100, 8'd50, 8'h96, 1'b0, 1'b1);
        issue(OP_SUB, 8'h9C, 8'd50, 8'h6A, 1'b0, 1'b1);
        issue(OP_ADD, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b1);
        issue(OP_SUB, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1);
`endif
        issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        issue(OP_RSV, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
        issue(OP_MUL, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b0);

        // MUL 3*3 aborted by RESET in its 4th busy cycle: no DONE may follow.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.data1 = 8'd3;
        bus.data2 = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_busy_cleared", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        issue(OP_ADD, 8'd2, 8'hFB, 8'hFD, 1'b0, 1'b0);

        // Back-to-back: START held through the FIN cycle of the first op.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        bus.data1 = 8'd10;
        bus.data2 = 8'd20;
        push_exp(8'd30, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        check("b2b_first_done", 32'(bus.done), 32'd1);
        bus.op = OP_SUB;
        push_exp(8'hF6, 1'b0, 1'b0, cyc + 1);
        @(negedge clk);
        check("b2b_second_done", 32'(bus.done), 32'd1);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
